// File: rtl/button_conditioner.sv
// +----------------------------------------------------------------------------+
// | button_conditioner                                                         |
// | Five-channel sync / debounce / one-shot with auto-repeat on L, U, R, D.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 7500000,
  parameter int CNT_W           = 25
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       BtnL_raw,
  input  logic       BtnU_raw,
  input  logic       BtnR_raw,
  input  logic       BtnD_raw,
  input  logic       BtnC_raw,
  output logic       BtnL,
  output logic       BtnU,
  output logic       BtnR,
  output logic       BtnD,
  output logic       BtnC,
  output logic [4:0] Btn_held
);

  localparam logic [2:0] c_IDLE        = 3'd0;
  localparam logic [2:0] c_DEB_PRESS   = 3'd1;
  localparam logic [2:0] c_HELD        = 3'd2;
  localparam logic [2:0] c_REPEAT      = 3'd3;
  localparam logic [2:0] c_DEB_RELEASE = 3'd4;

  localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [4:0] w_raw;
  logic [4:0] w_pulse;
  logic [4:0] w_held;

  assign w_raw = {BtnC_raw, BtnD_raw, BtnR_raw, BtnU_raw, BtnL_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_chan
      // Index 4 is the centre/select button, which must never auto-repeat.
      localparam bit c_REPEAT_EN = (gi != 4);

      logic             r_s1;
      logic             r_s2;
      logic [2:0]       r_state;
      logic [2:0]       w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             r_pulse;
      logic             w_pulse_nxt;
      logic             w_held_ch;

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_s1 <= 1'b0;
          r_s2 <= 1'b0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
        end
      end

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
          r_pulse <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
          r_pulse <= w_pulse_nxt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        case (r_state)
          c_IDLE: begin
            if (r_s2) begin
              w_state_nxt = c_DEB_PRESS;
              w_cnt_nxt   = '0;
            end
          end
          c_DEB_PRESS: begin
            if (!r_s2) begin
              w_state_nxt = c_IDLE;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_DEB_LAST) begin
              w_state_nxt = c_HELD;
              w_cnt_nxt   = '0;
              w_pulse_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          c_HELD: begin
            if (!r_s2) begin
              w_state_nxt = c_DEB_RELEASE;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_DLY_LAST) begin
              // Without repeat the counter parks at its limit for the rest of the hold.
              if (c_REPEAT_EN) begin
                w_state_nxt = c_REPEAT;
                w_cnt_nxt   = '0;
                w_pulse_nxt = 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          c_REPEAT: begin
            if (!r_s2) begin
              w_state_nxt = c_DEB_RELEASE;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_PER_LAST) begin
              w_cnt_nxt   = '0;
              w_pulse_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          c_DEB_RELEASE: begin
            if (r_s2) begin
              w_state_nxt = c_HELD;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_DEB_LAST) begin
              w_state_nxt = c_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          default: begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end

      always_comb begin
        w_held_ch = (r_state == c_HELD) || (r_state == c_REPEAT) ||
                    (r_state == c_DEB_RELEASE);
      end

      assign w_pulse[gi] = r_pulse;
      assign w_held[gi]  = w_held_ch;
    end
  endgenerate

  assign BtnL     = w_pulse[0];
  assign BtnU     = w_pulse[1];
  assign BtnR     = w_pulse[2];
  assign BtnD     = w_pulse[3];
  assign BtnC     = w_pulse[4];
  assign Btn_held = w_held;

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Sits directly upstream of game_logic.
- Converts the five raw board push-buttons (L, U, R, D, C) into clean single-cycle command pulses for game_logic's BtnL/BtnU/BtnR/BtnD/BtnC inputs. Each cursor move or select is therefore one event per press.
- Per button: 2-flop synchroniser, debounce on press and on release, one-shot pulse generation.
- Auto-repeat on the four direction buttons, so a held direction keeps stepping the highlight square; none on BtnC.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles the synchronised input must stay stable to accept a press or release (10 ms @ 50 MHz).
- REPEAT_DELAY, 25000000: cycles held after the first pulse before the first repeat pulse (500 ms).
- REPEAT_PERIOD, 7500000: cycles between subsequent repeat pulses (150 ms).
- CNT_W, 25: counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) - 1.

Ports:
- Clk, input, 1: system clock.
- Reset_n, input, 1: asynchronous active-low reset.
- BtnL_raw, input, 1: raw left button, asynchronous, active-high.
- BtnU_raw, input, 1: raw up button.
- BtnR_raw, input, 1: raw right button.
- BtnD_raw, input, 1: raw down button.
- BtnC_raw, input, 1: raw centre/select button.
- BtnL, output, 1: one-cycle left pulse to game_logic.
- BtnU, output, 1: one-cycle up pulse.
- BtnR, output, 1: one-cycle right pulse.
- BtnD, output, 1: one-cycle down pulse.
- BtnC, output, 1: one-cycle select pulse; never repeats.
- Btn_held, output, 5: debounced level {C,D,R,U,L}; 1 while the channel is in HELD, REPEAT or DEB_RELEASE.

Behaviour:
- One clock domain (Clk). Reset_n is asynchronous, active-low. Reset drives all of the following to 0 immediately, independent of Clk:
  - sync flops and counters;
  - all pulse outputs and Btn_held;
  - every channel FSM to IDLE.
- Five identical channels. Repeat is enabled for L/U/R/D and disabled for C. Channels are fully independent: simultaneous pulses on several outputs are legal and are passed through unarbitrated.
- Synchroniser: raw -> s1 -> s2 on each rising edge. The FSM sees only s2.
- FSM, per channel; cnt is CNT_W bits:
  - IDLE: s2=1 -> DEB_PRESS, cnt=0.
  - DEB_PRESS: s2=0 -> IDLE, no pulse. s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt=0, pulse. Otherwise cnt+1.
  - HELD: s2=0 -> DEB_RELEASE, cnt=0. Repeat-enabled channel with cnt==REPEAT_DELAY-1 -> REPEAT, cnt=0, pulse. Otherwise cnt+1. A repeat-disabled channel saturates cnt at REPEAT_DELAY-1 and never pulses again.
  - REPEAT: s2=0 -> DEB_RELEASE, cnt=0. cnt==REPEAT_PERIOD-1 -> pulse, cnt=0. Otherwise cnt+1.
  - DEB_RELEASE: s2=1 -> HELD, cnt=0, no pulse, repeat timer restarts. s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt+1.
- Pulse outputs are registered: high for exactly one cycle, in the cycle following the edge that made the transition. Never two consecutive high cycles.
- Press latency, with raw first sampled high at edge 0 and held:
  - DEB_PRESS is entered at edge 2;
  - the pulse register is set at edge DEBOUNCE_CYCLES+2.
- Btn_held rises at the same edge as the press pulse. It falls at the edge DEB_RELEASE -> IDLE.
- Glitch shorter than DEBOUNCE_CYCLES: no pulse, and Btn_held is unchanged.
- Button held across reset deassertion: treated as a fresh press; exactly one pulse after the standard latency.
- Reset asserted mid-count or mid-pulse: the pulse is truncated immediately, and nothing is emitted after release unless the button is still held.
- Counters never wrap: every state compares with == against its limit and clears cnt on leaving. CNT_W is sized so that all limits fit.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CNT_W=4):
1. Clean press: BtnU_raw high at edge 0, held for 8 cycles, then low -> BtnU high only in the cycle after edge 6; Btn_held[1] rises at edge 6; all other outputs 0.
2. Bounce: BtnL_raw toggles 1,0,1,0 on consecutive edges, then stays high -> no pulse during the bounce; exactly one BtnL pulse 6 edges after the final rise.
3. Auto-repeat: BtnR_raw held for 40 cycles -> first pulse after edge 6, then pulses at edges 16, 19, 22, 25, ...; released -> no further pulses; Btn_held[2] clears 4 cycles after s2 falls.
4. Centre hold: BtnC_raw held for 40 cycles -> exactly one BtnC pulse (after edge 6); Btn_held[4]=1 throughout the hold.
5. Release glitch: in HELD, a 2-cycle low on BtnD_raw -> no new pulse; Btn_held[3] stays 1; repeat timer restarts, so the next repeat comes 10 cycles after s2 returns high.
6. Reset: Reset_n low for 1 cycle while BtnL_raw is held and in REPEAT -> all outputs 0 at once; after release, one pulse 6 edges later, then the normal repeat cadence.
